priority_encoder: RTL and testbench

PRIORITY_ENCODER -- requirements
Module: priority_encoder

---
 rtl/priority_encoder_comb.sv | 17 +
 rtl/priority_encoder.sv | 30 +++
 tb/tb_priority_encoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/priority_encoder_comb.sv
// priority_encoder_comb: MSB-first priority encoder, index of highest set bit plus any-set flag.
module priority_encoder_comb #(
    parameter int WIDTH = 4,
    localparam int YW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] d,
    output logic [YW-1:0]    idx,
    output logic             any
);
    // Ascending scan so the highest set bit is the last one to write idx.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (d[i]) idx = YW'(i);
    end
    assign any = |d;
endmodule

// File: rtl/priority_encoder.sv
// priority_encoder: registered MSB-first priority encoder with one-cycle latency.
module priority_encoder #(
    parameter int WIDTH = 4,
    localparam int YW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [YW-1:0]    y,
    output logic             valid
);
    logic [YW-1:0] y_d, y_q;
    logic          valid_d, valid_q;
    priority_encoder_comb #(.WIDTH(WIDTH)) u_comb (
        .d  (d),
        .idx(y_d),
        .any(valid_d)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end
    assign y     = y_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_priority_encoder.sv
// tb_priority_encoder: table, directed and random checks of priority_encoder at WIDTH 4, 5 and 8.
module tb_priority_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] d4 = '0;
    logic [4:0] d5 = '0;
    logic [7:0] d8 = '0;
    logic [1:0] y4;
    logic [2:0] y5, y8;
    logic v4, v5, v8;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    priority_encoder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .d(d4), .y(y4), .valid(v4));
    priority_encoder #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .d(d5), .y(y5), .valid(v5));
    priority_encoder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .d(d8), .y(y8), .valid(v8));

    // Reference: floor(log2(v)) by repeated halving; 0 when nothing is set.
    function automatic int ref_idx(input longint unsigned v);
        int n = 0;
        while (v > 1) begin
            v = v / 2;
            n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] d;
        logic [1:0] y;
        logic       v;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl = '{
            '{4'b0000, 2'd0, 1'b0}, '{4'b0001, 2'd0, 1'b1}, '{4'b0010, 2'd1, 1'b1},
            '{4'b0100, 2'd2, 1'b1}, '{4'b1000, 2'd3, 1'b1}, '{4'b1010, 2'd3, 1'b1},
            '{4'b1111, 2'd3, 1'b1}, '{4'b0110, 2'd2, 1'b1}, '{4'b0011, 2'd1, 1'b1},
            '{4'b0000, 2'd0, 1'b0}
        };
        // Reset with zero input, then one clock after release.
        #2;
        check("reset_y", y4, 0);
        check("reset_v", v4, 0);
        d4 = 4'b1111;
        tick();
        check("hold_in_reset_y", y4, 0);
        check("hold_in_reset_v", v4, 0);
        @(negedge clk);
        d4 = 4'b0000;
        rst = 1'b0;
        tick();
        check("post_reset_y", y4, 0);
        check("post_reset_v", v4, 0);
        // Table vectors, including the one-hot walk and multi-bit cases.
        foreach (tbl[k]) begin
            @(negedge clk);
            d4 = tbl[k].d;
            tick();
            check($sformatf("tbl%0d_y", k), y4, tbl[k].y);
            check($sformatf("tbl%0d_v", k), v4, tbl[k].v);
        end
        // Latency: y must not move until the rising edge after d changes.
        @(negedge clk);
        d4 = 4'b0001;
        tick();
        check("lat_start_y", y4, 0);
        @(negedge clk);
        d4 = 4'b1000;
        #1;
        check("lat_before_edge_y", y4, 0);
        tick();
        check("lat_after_edge_y", y4, 3);
        // Asynchronous reset between edges.
        @(negedge clk);
        #1;
        check("pre_async_y", y4, 3);
        rst = 1'b1;
        #1;
        check("async_y", y4, 0);
        check("async_v", v4, 0);
        @(negedge clk);
        d4 = 4'b0000;
        rst = 1'b0;
        tick();
        check("no_replay_y", y4, 0);
        check("no_replay_v", v4, 0);
        // Random stimulus at WIDTH=4 against the reference model.
        for (int i = 0; i < 100; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            @(negedge clk);
            d4 = r;
            tick();
            check("rand4_y", y4, ref_idx(r));
            check("rand4_v", v4, r != 0);
        end
        // Exhaustive sweep at WIDTH=5 and WIDTH=8.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            d5 = 5'(i);
            d8 = 8'(i);
            tick();
            if (i < 32) begin
                check("sweep5_y", y5, ref_idx(i));
                check("sweep5_v", v5, i != 0);
            end
            check("sweep8_y", y8, ref_idx(i));
            check("sweep8_v", v8, i != 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
